// File: rtl/up_packet_interface.sv
// up_packet_interface: uP-side bus slave.
// Synchronises the uP strobes and collects a 6-byte command packet
// (cmd, address, data LSB first). It issues the packet to the register file,
// returns an 8-byte reply (data then status, LSB first) and then holds uP_ack.
// Optional feature: define UP_TIMEOUT_EN to add a handshake watchdog and a
// sticky timeout_err output.
module up_packet_interface #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned NOS_RX_BYTES    = 6,
    parameter int unsigned NOS_TX_BYTES    = 8,
    parameter int unsigned ACK_HOLD_CYCLES = 4
`ifdef UP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES  = 50000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        async_uP_start,
    input  logic        async_uP_handshake_1,
    input  logic        async_uP_RW,
    input  logic [7:0]  uP_data_in,
    output logic [7:0]  uP_data_out,
    output logic        uP_data_oe,
    output logic        uP_handshake_2,
    output logic        uP_ack,
`ifdef UP_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic [7:0]  reg_address,
    output logic [31:0] reg_data,
    input  logic        reply_valid,
    input  logic [31:0] reply_data,
    input  logic [31:0] reply_status
);

    localparam int unsigned MAX_BYTES = (NOS_TX_BYTES > NOS_RX_BYTES) ? NOS_TX_BYTES : NOS_RX_BYTES;
    localparam int unsigned CW        = $clog2(MAX_BYTES + 1);
    localparam int unsigned HW        = $clog2(ACK_HOLD_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, RX_H1_HI, RX_H1_LO, EXEC, WAIT_REPLY,
        TX_PRESENT, TX_H1_HI, TX_H1_LO, DONE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] start_sync, h1_sync, rw_sync;
    logic start_s, h1_s, rw_s, start_prev, start_rise;

    logic [CW-1:0] count, count_n, count_inc;
    logic [HW-1:0] hold, hold_n;
    logic [7:0]    rx_buf   [NOS_RX_BYTES];
    logic [7:0]    rx_buf_n [NOS_RX_BYTES];
    logic [7:0]    tx_buf   [NOS_TX_BYTES];
    logic [7:0]    tx_buf_n [NOS_TX_BYTES];
    logic [8*NOS_TX_BYTES-1:0] reply_vec;

    logic [7:0]  data_out_n, cmd_n, addr_n;
    logic [31:0] wdata_n;
    logic        oe_n, h2_n, ack_n, cmd_valid_n;

    assign start_s    = start_sync[SYNC_STAGES-1];
    assign h1_s       = h1_sync[SYNC_STAGES-1];
    assign rw_s       = rw_sync[SYNC_STAGES-1];
    assign start_rise = start_s & ~start_prev;
    assign count_inc  = count + 1'b1;
    assign reply_vec  = {reply_status, reply_data};

`ifdef UP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;
    logic          timeout_err_n;
`endif

    // Synchronise the asynchronous strobes and remember the previous start level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_sync <= '0;
            h1_sync    <= '0;
            rw_sync    <= '0;
            start_prev <= 1'b0;
        end else begin
            start_sync <= {start_sync[SYNC_STAGES-2:0], async_uP_start};
            h1_sync    <= {h1_sync[SYNC_STAGES-2:0], async_uP_handshake_1};
            rw_sync    <= {rw_sync[SYNC_STAGES-2:0], async_uP_RW};
            start_prev <= start_s;
        end
    end

    // State register plus all registered outputs and buffers; the async reset
    // drops uP_data_oe immediately so the bus is released mid-transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            hold           <= '0;
            uP_data_out    <= '0;
            uP_data_oe     <= 1'b0;
            uP_handshake_2 <= 1'b0;
            uP_ack         <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd            <= '0;
            reg_address    <= '0;
            reg_data       <= '0;
            for (int unsigned i = 0; i < NOS_RX_BYTES; i++) rx_buf[i] <= '0;
            for (int unsigned i = 0; i < NOS_TX_BYTES; i++) tx_buf[i] <= '0;
        end else begin
            state          <= state_n;
            count          <= count_n;
            hold           <= hold_n;
            uP_data_out    <= data_out_n;
            uP_data_oe     <= oe_n;
            uP_handshake_2 <= h2_n;
            uP_ack         <= ack_n;
            cmd_valid      <= cmd_valid_n;
            cmd            <= cmd_n;
            reg_address    <= addr_n;
            reg_data       <= wdata_n;
            rx_buf         <= rx_buf_n;
            tx_buf         <= tx_buf_n;
        end
    end

`ifdef UP_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt     <= tmo_cnt_n;
            timeout_err <= timeout_err_n;
        end
    end
`endif

    // Next-state, handshake and datapath decisions.
    always_comb begin
        state_n     = state;
        count_n     = count;
        hold_n      = hold;
        rx_buf_n    = rx_buf;
        tx_buf_n    = tx_buf;
        data_out_n  = uP_data_out;
        oe_n        = uP_data_oe;
        h2_n        = uP_handshake_2;
        ack_n       = uP_ack;
        cmd_valid_n = 1'b0;
        cmd_n       = cmd;
        addr_n      = reg_address;
        wdata_n     = reg_data;

        case (state)
            IDLE: begin
                if (start_rise) begin
                    count_n = '0;
                    state_n = RX_H1_HI;
                end
            end
            RX_H1_HI: begin
                if (h1_s && rw_s) begin
                    for (int unsigned i = 0; i < NOS_RX_BYTES; i++)
                        if (count == CW'(i)) rx_buf_n[i] = uP_data_in;
                    h2_n    = 1'b1;
                    state_n = RX_H1_LO;
                end
            end
            RX_H1_LO: begin
                if (!h1_s) begin
                    h2_n    = 1'b0;
                    count_n = count_inc;
                    state_n = (count == CW'(NOS_RX_BYTES - 1)) ? EXEC : RX_H1_HI;
                end
            end
            EXEC: begin
                cmd_n       = rx_buf[0];
                addr_n      = rx_buf[1];
                wdata_n     = {rx_buf[5], rx_buf[4], rx_buf[3], rx_buf[2]};
                cmd_valid_n = 1'b1;
                state_n     = WAIT_REPLY;
            end
            WAIT_REPLY: begin
                if (reply_valid) begin
                    for (int unsigned i = 0; i < NOS_TX_BYTES; i++)
                        tx_buf_n[i] = reply_vec[8*i +: 8];
                    count_n    = '0;
                    oe_n       = 1'b1;
                    data_out_n = reply_vec[7:0];
                    state_n    = TX_PRESENT;
                end
            end
            TX_PRESENT: begin
                // Byte has been on the bus for one clock; now strobe it.
                h2_n    = 1'b1;
                state_n = TX_H1_HI;
            end
            TX_H1_HI: begin
                if (h1_s) begin
                    h2_n    = 1'b0;
                    state_n = TX_H1_LO;
                end
            end
            TX_H1_LO: begin
                if (!h1_s) begin
                    count_n = count_inc;
                    if (count == CW'(NOS_TX_BYTES - 1)) begin
                        oe_n       = 1'b0;
                        data_out_n = '0;
                        ack_n      = 1'b1;
                        hold_n     = '0;
                        state_n    = DONE;
                    end else begin
                        for (int unsigned i = 0; i < NOS_TX_BYTES; i++)
                            if (count_inc == CW'(i)) data_out_n = tx_buf[i];
                        state_n = TX_PRESENT;
                    end
                end
            end
            DONE: begin
                if (hold < HW'(ACK_HOLD_CYCLES - 1)) begin
                    hold_n = hold + 1'b1;
                end else if (!start_s) begin
                    ack_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef UP_TIMEOUT_EN
        timeout_err_n = timeout_err;
        if (state == IDLE && start_rise) timeout_err_n = 1'b0;
        if (state != IDLE && state != WAIT_REPLY && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n       = IDLE;
            h2_n          = 1'b0;
            oe_n          = 1'b0;
            ack_n         = 1'b0;
            data_out_n    = '0;
            timeout_err_n = 1'b1;
        end
        if (state_n != state || state == IDLE || state == WAIT_REPLY)
            tmo_cnt_n = '0;
        else
            tmo_cnt_n = tmo_cnt + 1'b1;
`endif
    end

endmodule

// File: tb/tb_up_packet_interface.sv
// Scoreboard bench for up_packet_interface: the uP/register-file driver pushes
// the expected command fields and reply bytes; a negedge monitor pops and compares.
module tb_up_packet_interface;

    localparam int unsigned ACK_HOLD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        async_uP_start = 1'b0;
    logic        async_uP_handshake_1 = 1'b0;
    logic        async_uP_RW = 1'b0;
    logic [7:0]  uP_data_in = '0;
    logic [7:0]  uP_data_out;
    logic        uP_data_oe, uP_handshake_2, uP_ack, cmd_valid;
    logic [7:0]  cmd, reg_address;
    logic [31:0] reg_data;
    logic        reply_valid = 1'b0;
    logic [31:0] reply_data = '0, reply_status = '0;
`ifdef UP_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 clk = ~clk;

    up_packet_interface #(
        .ACK_HOLD_CYCLES(ACK_HOLD)
`ifdef UP_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .async_uP_start(async_uP_start),
        .async_uP_handshake_1(async_uP_handshake_1),
        .async_uP_RW(async_uP_RW),
        .uP_data_in(uP_data_in), .uP_data_out(uP_data_out),
        .uP_data_oe(uP_data_oe), .uP_handshake_2(uP_handshake_2),
        .uP_ack(uP_ack),
`ifdef UP_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .cmd_valid(cmd_valid), .cmd(cmd), .reg_address(reg_address),
        .reg_data(reg_data), .reply_valid(reply_valid),
        .reply_data(reply_data), .reply_status(reply_status)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  c;
        logic [7:0]  a;
        logic [31:0] d;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_tx[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    logic       prev_h2, prev_oe, prev_cv, prev_ack;
    logic [7:0] prev_out;
    int         ack_cnt;
    cmd_t       mc;
    logic [7:0] mb;
    always @(negedge clk) begin
        if (reset) begin
            prev_h2 = 0; prev_oe = 0; prev_cv = 0; prev_ack = 0; prev_out = 0; ack_cnt = 0;
        end else begin
            if (cmd_valid) begin
                chk("cmd_valid_single", prev_cv, 0);
                if (exp_cmd.size() == 0) fail_now("cmd_valid_unexpected");
                else begin
                    mc = exp_cmd.pop_front();
                    chk("cmd", cmd, mc.c);
                    chk("reg_address", reg_address, mc.a);
                    chk("reg_data", reg_data, mc.d);
                    chk("oe_at_exec", uP_data_oe, 0);
                end
            end
            if (uP_handshake_2 && !prev_h2 && uP_data_oe) begin
                if (exp_tx.size() == 0) fail_now("tx_byte_unexpected");
                else begin
                    mb = exp_tx.pop_front();
                    chk("tx_byte", uP_data_out, mb);
                end
                chk("tx_data_lead", {prev_oe, prev_out}, {1'b1, uP_data_out});
            end
            if (uP_ack) begin
                if (!prev_ack) chk("oe_at_ack", uP_data_oe, 0);
                ack_cnt++;
            end else if (prev_ack) begin
                chk("ack_hold", 64'(ack_cnt >= ACK_HOLD), 1);
                ack_cnt = 0;
            end
            prev_h2 = uP_handshake_2; prev_oe = uP_data_oe; prev_cv = cmd_valid;
            prev_ack = uP_ack; prev_out = uP_data_out;
        end
    end

    task automatic wait_h2(input logic level, input string name);
        int n = 0;
        while (uP_handshake_2 !== level && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (uP_handshake_2 !== level) fail_now(name);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, output bit ok);
        uP_data_in  = b;
        async_uP_RW = 1'b1;
        @(posedge clk); #1;
        async_uP_handshake_1 = 1'b1;
        wait_h2(1'b1, "rx_h2_rise_timeout");
        ok = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (uP_handshake_2 !== 1'b1) ok = 1'b0;
        end
        async_uP_handshake_1 = 1'b0;
        wait_h2(1'b0, "rx_h2_fall_timeout");
    endtask

    task automatic recv_byte();
        async_uP_RW = 1'b0;
        wait_h2(1'b1, "tx_h2_rise_timeout");
        @(posedge clk); #1;
        async_uP_handshake_1 = 1'b1;
        wait_h2(1'b0, "tx_h2_fall_timeout");
        async_uP_handshake_1 = 1'b0;
    endtask

    task automatic pulse_start();
        async_uP_start = 1'b1;
        repeat (4) @(posedge clk);
        #1 async_uP_start = 1'b0;
    endtask

    task automatic mid_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("reset_outputs_immediate",
            {uP_data_out, uP_data_oe, uP_handshake_2, uP_ack, cmd_valid, cmd, reg_address, reg_data}, '0);
        repeat (2) @(posedge clk);
        exp_cmd.delete();
        exp_tx.delete();
        async_uP_handshake_1 = 1'b0; async_uP_RW = 1'b0; async_uP_start = 1'b0; reply_valid = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // One uP transaction plus the register-file reply. rst_at < 6 resets before
    // RX byte rst_at; 6..13 resets before TX byte rst_at-6; -1 runs to completion.
    task automatic run_txn(input logic [7:0] c, input logic [7:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input logic [31:0] st, input int hold,
                           input bit spur, input bit start_tx, input int rst_at);
        logic [7:0] b[6];
        bit ok;
        int n;
        b[0] = c; b[1] = a;
        for (int i = 0; i < 4; i++) b[2+i] = 8'(wd >> (8*i));
        exp_cmd.push_back('{c, a, wd});
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            if (rst_at == i) begin mid_reset(); return; end
            send_byte(b[i], hold, ok);
            chk("rx_h2_held", ok, 1);
            if (spur && i == 2) begin
                @(posedge clk); #1;
                reply_data = $urandom; reply_status = $urandom; reply_valid = 1'b1;
                @(posedge clk); #1 reply_valid = 1'b0;
            end
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_valid && n < 100);
        if (!cmd_valid) fail_now("cmd_valid_timeout");
        repeat ($urandom_range(0, 5)) @(posedge clk);
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'(rd >> (8*i)));
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'(st >> (8*i)));
        @(posedge clk); #1;
        reply_data = rd; reply_status = st; reply_valid = 1'b1;
        @(posedge clk); #1;
        reply_valid = 1'b0; reply_data = $urandom; reply_status = $urandom;
        for (int i = 0; i < 8; i++) begin
            if (rst_at == 6 + i) begin mid_reset(); return; end
            recv_byte();
            if (start_tx && i == 3) pulse_start();
        end
        n = 0;
        while (!uP_ack && n < 100) begin @(posedge clk); #1; n++; end
        if (!uP_ack) fail_now("ack_rise_timeout");
        n = 0;
        while (uP_ack && n < 100) begin @(posedge clk); #1; n++; end
        if (uP_ack) fail_now("ack_fall_timeout");
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            {uP_data_out, uP_data_oe, uP_handshake_2, uP_ack, cmd_valid, cmd, reg_address, reg_data}, '0);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        run_txn(8'h01, 8'h00, 32'h64, 32'h64, 32'h0, 1, 0, 0, -1);
        run_txn(8'h00, 8'h2A, 32'h0, 32'hDEADBEEF, 32'h1, 2, 0, 0, -1);
        run_txn(8'h01, 8'h17, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0, 30, 0, 0, -1);
        run_txn(8'h00, 8'h33, 32'h0, 32'h1234_5678, 32'h8000_0002, 1, 1, 1, -1);
        run_txn(8'h01, 8'h44, 32'h1111_2222, 32'h0, 32'h0, 1, 0, 0, 3);
        run_txn(8'h01, 8'h45, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0, 1, 0, 0, -1);
        run_txn(8'h00, 8'h46, 32'h0, 32'h0BAD_F00D, 32'h3, 1, 0, 0, 9);
        run_txn(8'h00, 8'h47, 32'h0, 32'h7654_3210, 32'hFFFF_FFFF, 0, 0, 0, -1);

        for (int t = 0; t < 6; t++)
            run_txn(8'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);

`ifdef UP_TIMEOUT_EN
        begin
            bit ok;
            int n;
            pulse_start();
            send_byte(8'h01, 1, ok);
            send_byte(8'h02, 1, ok);
            n = 0;
            while (!timeout_err && n < 300) begin @(posedge clk); #1; n++; end
            chk("timeout_err_set", timeout_err, 1);
            chk("timeout_delay_window", 64'(n >= 95 && n <= 105), 1);
            chk("timeout_outputs", {uP_handshake_2, uP_data_oe, uP_ack}, 0);
            run_txn(8'h01, 8'h09, 32'h99, 32'h99, 32'h0, 1, 0, 0, -1);
            chk("timeout_err_cleared", timeout_err, 0);
        end
`endif

        repeat (5) @(posedge clk);
        chk("cmd_queue_drained", exp_cmd.size(), 0);
        chk("tx_queue_drained", exp_tx.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        checks++;
        $display("FAIL global_time_limit: bench did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
